branch_resolve: RTL and testbench

- EX-stage counterpart to the IF/ID branch predictor.
- Queues each prediction issued at decode, then resolves the real branch outcome in EX from register operands.
- Compares the outcome against the queued prediction. On mismatch, drives pipeline flush plus redirect PC.
- Emits a training update back to the predictor and keeps branch/mispredict statistics.

---
 rtl/branch_resolve_pkg.sv | 31 +++
 rtl/bp_pred_fifo.sv | 49 ++++
 rtl/branch_resolve.sv | 142 ++++++++++++++
 tb/tb_branch_resolve.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_resolve_pkg.sv
// Shared MIPS branch decode constants, prediction-queue entry type and target helper
// for the EX-stage branch resolver.
package branch_resolve_pkg;

  localparam int INST_W = 32;
  typedef logic [INST_W-1:0] inst_bus_t;

  localparam logic [5:0] EXE_REGIMM_INST = 6'b000001;
  localparam logic [5:0] EXE_BEQ         = 6'b000100;
  localparam logic [5:0] EXE_BNE         = 6'b000101;
  localparam logic [5:0] EXE_BLEZ        = 6'b000110;
  localparam logic [5:0] EXE_BGTZ        = 6'b000111;

  localparam logic [4:0] EXE_BLTZ        = 5'b00000;
  localparam logic [4:0] EXE_BGEZ        = 5'b00001;
  localparam logic [4:0] EXE_BLTZAL      = 5'b10000;
  localparam logic [4:0] EXE_BGEZAL      = 5'b10001;

  localparam logic BP_YES = 1'b1;
  localparam logic BP_NO  = 1'b0;

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
  } pred_entry_t;

  function automatic logic [31:0] branch_target(input logic [31:0] pc, input logic [15:0] imm);
    return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/bp_pred_fifo.sv
// Circular queue of pending branch predictions; clear empties it, and a push into a
// full queue is accepted only when a pop frees the head slot in the same cycle.
module bp_pred_fifo
  import branch_resolve_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  pred_entry_t push_data,
  output logic        full,
  output logic        empty,
  output pred_entry_t head
);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W:0]   cnt;
  pred_entry_t      mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign full    = (cnt == (PTR_W+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign head    = mem[rd_ptr];
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{PTR_W{1'b0}}, do_push} - {{PTR_W{1'b0}}, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/branch_resolve.sv
// EX-stage branch resolution: checks the real outcome against the prediction queued at
// decode, raises flush/redirect on mispredicts and trains the predictor.
module branch_resolve
  import branch_resolve_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  input  logic        pred_taken,
  output logic        pred_ready,
  input  logic        ex_valid,
  input  inst_bus_t   ex_inst,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_rs_data,
  input  logic [31:0] ex_rt_data,
  input  logic        ex_flush_in,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        upd_valid,
  output logic [31:0] upd_pc,
  output logic        upd_taken,
  output logic        link_valid,
  output logic [31:0] link_addr,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispredict_cnt,
  output logic        q_err
);

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  logic [5:0]         opcode_p0;
  logic [4:0]         rt_sel_p0;
  logic [15:0]        imm_p0;
  logic signed [31:0] rs_p0;
  logic signed [31:0] rt_p0;
  logic               unused_rs_field;
  logic               is_br_p0;
  logic               is_link_p0;
  logic               actual_p0;
  logic               resolve_p0;
  logic               head_hit_p0;
  logic               predicted_p0;
  logic               mispredict_p0;
  logic               pop_p0;
  logic               push_ok_p0;
  logic               q_err_set_p0;
  logic               full;
  logic               empty;
  pred_entry_t        head;

  assign opcode_p0       = ex_inst[31:26];
  assign rt_sel_p0       = ex_inst[20:16];
  assign imm_p0          = ex_inst[15:0];
  assign unused_rs_field = ^ex_inst[25:21];
  assign rs_p0           = signed'(ex_rs_data);
  assign rt_p0           = signed'(ex_rt_data);

  always_comb begin
    is_br_p0   = 1'b0;
    is_link_p0 = 1'b0;
    actual_p0  = 1'b0;
    case (opcode_p0)
      EXE_BEQ:  begin is_br_p0 = 1'b1; actual_p0 = (rs_p0 == rt_p0);  end
      EXE_BNE:  begin is_br_p0 = 1'b1; actual_p0 = (rs_p0 != rt_p0);  end
      EXE_BGTZ: begin is_br_p0 = 1'b1; actual_p0 = (rs_p0 >  32'sd0); end
      EXE_BLEZ: begin is_br_p0 = 1'b1; actual_p0 = (rs_p0 <= 32'sd0); end
      EXE_REGIMM_INST: begin
        case (rt_sel_p0)
          EXE_BGEZ:   begin is_br_p0 = 1'b1; actual_p0 = (rs_p0 >= 32'sd0); end
          EXE_BLTZ:   begin is_br_p0 = 1'b1; actual_p0 = (rs_p0 <  32'sd0); end
          EXE_BGEZAL: begin is_br_p0 = 1'b1; is_link_p0 = 1'b1; actual_p0 = (rs_p0 >= 32'sd0); end
          EXE_BLTZAL: begin is_br_p0 = 1'b1; is_link_p0 = 1'b1; actual_p0 = (rs_p0 <  32'sd0); end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  // An unmatched head is still consumed so the queue re-aligns with the real branch stream.
  assign resolve_p0    = ex_valid && is_br_p0 && !ex_flush_in;
  assign head_hit_p0   = !empty && (head.pc == ex_pc);
  assign predicted_p0  = head_hit_p0 ? head.taken : BP_NO;
  assign mispredict_p0 = (actual_p0 != predicted_p0);
  assign pop_p0        = resolve_p0 && !empty;
  assign push_ok_p0    = pred_valid && (!full || pop_p0);
  assign q_err_set_p0  = (pred_valid && !push_ok_p0) || (resolve_p0 && !head_hit_p0);
  assign pred_ready    = !full;

  bp_pred_fifo #(
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_ok_p0),
    .pop       (pop_p0),
    .clear     (flush || ex_flush_in),
    .push_data ('{pc: pred_pc, taken: pred_taken}),
    .full      (full),
    .empty     (empty),
    .head      (head)
  );

  // ---- p0 -> p1: registered resolution outputs ----
  always_ff @(posedge clk) begin
    if (rst) begin
      flush          <= 1'b0;
      redirect_pc    <= '0;
      upd_valid      <= 1'b0;
      upd_pc         <= '0;
      upd_taken      <= 1'b0;
      link_valid     <= 1'b0;
      link_addr      <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
      q_err          <= 1'b0;
    end else begin
      flush      <= resolve_p0 && mispredict_p0;
      upd_valid  <= resolve_p0;
      link_valid <= resolve_p0 && is_link_p0;
      q_err      <= q_err || q_err_set_p0;
      if (resolve_p0) begin
        upd_pc     <= ex_pc;
        upd_taken  <= actual_p0;
        branch_cnt <= sat_inc(branch_cnt);
      end
      if (resolve_p0 && mispredict_p0) begin
        redirect_pc    <= actual_p0 ? branch_target(ex_pc, imm_p0) : ex_pc + 32'd8;
        mispredict_cnt <= sat_inc(mispredict_cnt);
      end
      if (resolve_p0 && is_link_p0) link_addr <= ex_pc + 32'd8;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: queue-based reference model compared every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_branch_resolve;

  localparam int DEPTH = 4;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;
  localparam logic [5:0] OP_ADDI   = 6'b001000;
  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;
  localparam logic [4:0] RT_BLTZAL = 5'b10000;
  localparam logic [4:0] RT_BGEZAL = 5'b10001;

  logic        clk = 1'b0;
  logic        rst;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        pred_taken;
  logic        pred_ready;
  logic        ex_valid;
  logic [31:0] ex_inst;
  logic [31:0] ex_pc;
  logic [31:0] ex_rs_data;
  logic [31:0] ex_rt_data;
  logic        ex_flush_in;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic        link_valid;
  logic [31:0] link_addr;
  logic [31:0] branch_cnt;
  logic [31:0] mispredict_cnt;
  logic        q_err;

  always #5 clk = ~clk;

  branch_resolve #(.DEPTH(DEPTH), .PTR_W(2)) dut (
    .clk(clk), .rst(rst),
    .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken), .pred_ready(pred_ready),
    .ex_valid(ex_valid), .ex_inst(ex_inst), .ex_pc(ex_pc),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_flush_in(ex_flush_in),
    .flush(flush), .redirect_pc(redirect_pc),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
    .link_valid(link_valid), .link_addr(link_addr),
    .branch_cnt(branch_cnt), .mispredict_cnt(mispredict_cnt), .q_err(q_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of {pc, taken} plus the expected registered outputs.
  typedef struct packed { logic [31:0] pc; logic taken; } ent_t;
  ent_t        mq[$];
  logic        model_on = 1'b0;
  logic        e_flush, e_upd_valid, e_upd_taken, e_link_valid, e_q_err;
  logic [31:0] e_redirect, e_upd_pc, e_link_addr, e_branch, e_misp;

  function automatic void classify(input logic [31:0] inst, input logic [31:0] rs, input logic [31:0] rt,
                                   output logic br, output logic lnk, output logic taken);
    int signed a = int'(rs);
    int signed b = int'(rt);
    br = 1'b1; lnk = 1'b0; taken = 1'b0;
    if (inst[31:26] == OP_BEQ)       taken = (a == b);
    else if (inst[31:26] == OP_BNE)  taken = (a != b);
    else if (inst[31:26] == OP_BGTZ) taken = (a > 0);
    else if (inst[31:26] == OP_BLEZ) taken = (a <= 0);
    else if (inst[31:26] == OP_REGIMM && (inst[20:16] == RT_BGEZ || inst[20:16] == RT_BGEZAL)) begin
      taken = (a >= 0); lnk = inst[20];
    end else if (inst[31:26] == OP_REGIMM && (inst[20:16] == RT_BLTZ || inst[20:16] == RT_BLTZAL)) begin
      taken = (a < 0); lnk = inst[20];
    end else br = 1'b0;
  endfunction

  task automatic model_step();
    logic br, lnk, act, res, clr, hit, pr, popd, pushd;
    logic [31:0] off;
    if (rst) begin
      mq.delete();
      model_on = 1'b1;
      {e_flush, e_upd_valid, e_upd_taken, e_link_valid, e_q_err} = '0;
      {e_redirect, e_upd_pc, e_link_addr, e_branch, e_misp} = '0;
      return;
    end
    classify(ex_inst, ex_rs_data, ex_rt_data, br, lnk, act);
    res   = ex_valid && br && !ex_flush_in;
    clr   = e_flush || ex_flush_in;
    hit   = (mq.size() > 0) && (mq[0].pc == ex_pc);
    pr    = hit ? mq[0].taken : 1'b0;
    popd  = res && (mq.size() > 0);
    pushd = pred_valid && ((mq.size() < DEPTH) || popd);
    if ((pred_valid && !pushd) || (res && !hit)) e_q_err = 1'b1;
    if (clr) mq.delete();
    else begin
      if (popd) void'(mq.pop_front());
      if (pushd) mq.push_back('{pc: pred_pc, taken: pred_taken});
    end
    e_flush      = res && (act != pr);
    e_upd_valid  = res;
    e_link_valid = res && lnk;
    if (res) begin
      e_upd_pc    = ex_pc;
      e_upd_taken = act;
      if (e_branch != 32'hFFFF_FFFF) e_branch = e_branch + 1;
    end
    if (res && lnk) e_link_addr = ex_pc + 8;
    if (e_flush) begin
      off        = {{16{ex_inst[15]}}, ex_inst[15:0]};
      e_redirect = act ? (ex_pc + 4 + off * 4) : (ex_pc + 8);
      if (e_misp != 32'hFFFF_FFFF) e_misp = e_misp + 1;
    end
  endtask

  always @(negedge clk) begin
    if (model_on) begin
      chk("flush", {31'd0, flush}, {31'd0, e_flush});
      chk("upd_valid", {31'd0, upd_valid}, {31'd0, e_upd_valid});
      chk("link_valid", {31'd0, link_valid}, {31'd0, e_link_valid});
      chk("q_err", {31'd0, q_err}, {31'd0, e_q_err});
      chk("pred_ready", {31'd0, pred_ready}, {31'd0, (mq.size() < DEPTH)});
      chk("branch_cnt", branch_cnt, e_branch);
      chk("mispredict_cnt", mispredict_cnt, e_misp);
      chk("redirect_pc", redirect_pc, e_redirect);
      chk("upd_pc", upd_pc, e_upd_pc);
      chk("upd_taken", {31'd0, upd_taken}, {31'd0, e_upd_taken});
      chk("link_addr", link_addr, e_link_addr);
    end
  end

  function automatic logic [31:0] mk(input logic [5:0] op, input logic [4:0] rt, input logic [15:0] imm);
    return {op, 5'd3, rt, imm};
  endfunction

  task automatic clr_in();
    rst = 1'b0; pred_valid = 1'b0; pred_pc = '0; pred_taken = 1'b0;
    ex_valid = 1'b0; ex_inst = '0; ex_pc = '0; ex_rs_data = '0; ex_rt_data = '0; ex_flush_in = 1'b0;
  endtask

  // Apply current inputs for one clock; returns once the resulting outputs are visible.
  task automatic go();
    model_step();
    @(negedge clk);
    #1;
    clr_in();
  endtask

  task automatic push(input logic [31:0] pc, input logic t);
    pred_valid = 1'b1; pred_pc = pc; pred_taken = t;
  endtask

  task automatic ex(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] rs, input logic [31:0] rt);
    ex_valid = 1'b1; ex_inst = inst; ex_pc = pc; ex_rs_data = rs; ex_rt_data = rt;
  endtask

  task automatic do_reset();
    rst = 1'b1; go();
    rst = 1'b1; go();
  endtask

  logic [31:0] rvals [6];

  initial begin
    clr_in();
    do_reset();
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_ready", {31'd0, pred_ready}, 32'd1);
    chk("rst_bcnt", branch_cnt, 32'd0);
    chk("rst_qerr", {31'd0, q_err}, 32'd0);

    push(32'h0040_0010, 1'b1); go();
    ex(mk(OP_BEQ, 5'd0, 16'h0004), 32'h0040_0010, 32'd5, 32'd5); go();
    chk("t1_flush", {31'd0, flush}, 32'd0);
    chk("t1_upd_valid", {31'd0, upd_valid}, 32'd1);
    chk("t1_upd_taken", {31'd0, upd_taken}, 32'd1);
    chk("t1_bcnt", branch_cnt, 32'd1);
    chk("t1_mcnt", mispredict_cnt, 32'd0);
    go();

    push(32'h0040_0020, 1'b0); go();
    ex(mk(OP_BNE, 5'd0, 16'hFFFC), 32'h0040_0020, 32'd1, 32'd2); go();
    chk("t2_flush", {31'd0, flush}, 32'd1);
    chk("t2_redirect", redirect_pc, 32'h0040_0014);
    chk("t2_mcnt", mispredict_cnt, 32'd1);
    go();

    push(32'h0040_0030, 1'b1); go();
    ex(mk(OP_REGIMM, RT_BLTZ, 16'h0010), 32'h0040_0030, 32'd0, 32'd0); go();
    chk("t3_flush", {31'd0, flush}, 32'd1);
    chk("t3_redirect", redirect_pc, 32'h0040_0038);
    go();
    push(32'h0040_0040, 1'b1); go();
    ex(mk(OP_REGIMM, RT_BGEZAL, 16'h0008), 32'h0040_0040, 32'd0, 32'd0); go();
    chk("t3_link_valid", {31'd0, link_valid}, 32'd1);
    chk("t3_link_addr", link_addr, 32'h0040_0048);
    chk("t3_flush_al", {31'd0, flush}, 32'd0);
    chk("t3_bcnt", branch_cnt, 32'd4);
    chk("t3_qerr", {31'd0, q_err}, 32'd0);

    for (int i = 0; i < 4; i++) begin push(32'h100 + 32'(i) * 4, 1'b1); go(); end
    chk("t4_ready_full", {31'd0, pred_ready}, 32'd0);
    push(32'h110, 1'b1); go();
    chk("t4_qerr_drop", {31'd0, q_err}, 32'd1);
    push(32'h200, 1'b1); ex(mk(OP_BEQ, 5'd0, 16'h0001), 32'h100, 32'd7, 32'd7); go();
    chk("t4_popush_ready", {31'd0, pred_ready}, 32'd0);
    chk("t4_popush_flush", {31'd0, flush}, 32'd0);

    do_reset();
    ex(mk(OP_BEQ, 5'd0, 16'h0002), 32'h300, 32'd9, 32'd9); go();
    chk("t5_qerr_empty", {31'd0, q_err}, 32'd1);
    chk("t5_flush_pred0", {31'd0, flush}, 32'd1);
    chk("t5_redirect", redirect_pc, 32'h0000_030C);
    go();

    for (int i = 0; i < 3; i++) begin push(32'h400 + 32'(i) * 4, 1'b0); go(); end
    ex(mk(OP_BEQ, 5'd0, 16'h0001), 32'h400, 32'd1, 32'd1); go();
    chk("t6_flush", {31'd0, flush}, 32'd1);
    push(32'h500, 1'b0); go();
    for (int i = 0; i < 3; i++) begin push(32'h600 + 32'(i) * 4, 1'b0); go(); end
    chk("t6_cleared_ready", {31'd0, pred_ready}, 32'd1);
    ex(mk(OP_BEQ, 5'd0, 16'h0001), 32'h600, 32'd1, 32'd1); ex_flush_in = 1'b1; go();
    chk("t6_xf_upd", {31'd0, upd_valid}, 32'd0);
    chk("t6_xf_bcnt", branch_cnt, 32'd2);
    chk("t6_xf_mcnt", mispredict_cnt, 32'd2);
    for (int i = 0; i < 3; i++) begin push(32'h700 + 32'(i) * 4, 1'b1); go(); end
    chk("t6_xf_ready3", {31'd0, pred_ready}, 32'd1);
    push(32'h70C, 1'b1); go();
    chk("t6_xf_ready4", {31'd0, pred_ready}, 32'd0);

    do_reset();
    push(32'h800, 1'b1); go();
    push(32'h804, 1'b1); go();
    rst = 1'b1; ex(mk(OP_BNE, 5'd0, 16'h0001), 32'h900, 32'd1, 32'd1); go();
    chk("t7_flush", {31'd0, flush}, 32'd0);
    chk("t7_upd", {31'd0, upd_valid}, 32'd0);
    chk("t7_ready", {31'd0, pred_ready}, 32'd1);
    chk("t7_bcnt", branch_cnt, 32'd0);
    chk("t7_qerr", {31'd0, q_err}, 32'd0);

    rvals[0] = 32'd0; rvals[1] = 32'd1; rvals[2] = 32'hFFFF_FFFF;
    rvals[3] = 32'h8000_0000; rvals[4] = 32'h7FFF_FFFF; rvals[5] = 32'h0000_1234;
    for (int c = 0; c < 3000; c++) begin
      logic [5:0] op;
      logic [4:0] rtf;
      logic [31:0] rs;
      case ($urandom_range(0, 9))
        0: op = OP_BEQ;  1: op = OP_BNE;  2: op = OP_BLEZ;  3: op = OP_BGTZ;
        4, 5, 6, 7: op = OP_REGIMM;
        default: op = OP_ADDI;
      endcase
      case ($urandom_range(0, 4))
        0: rtf = RT_BLTZ; 1: rtf = RT_BGEZ; 2: rtf = RT_BLTZAL; 3: rtf = RT_BGEZAL;
        default: rtf = 5'(5'b00010);
      endcase
      rs = ($urandom_range(0, 2) == 0) ? $urandom() : rvals[$urandom_range(0, 5)];
      rst = ($urandom_range(0, 99) == 0);
      if ($urandom_range(0, 1) == 1) push(32'h0040_0000 + 32'($urandom_range(0, 7)) * 4, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1)
        ex(mk(op, rtf, 16'($urandom())), 32'h0040_0000 + 32'($urandom_range(0, 7)) * 4, rs,
           ($urandom_range(0, 1) == 1) ? rs : $urandom());
      ex_flush_in = ($urandom_range(0, 19) == 0);
      go();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
